// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Memory-stage data bus between the pipeline (master) and the data memory
//   responder (slave).
//   re_m / we_m        load / store request
//   addr_m             byte address
//   wdata_m            right-aligned store data
//   funct3_m           access size and signedness
//   rdata_m            extended load result, valid while mem_valid_m=1
//   mem_valid_m        one-cycle load-complete pulse
//   misaligned_m       misalignment flag, present only with DMEM_MISALIGN_TRAP_EN
interface dmem_responder_if;
  logic        re_m;
  logic        we_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic [2:0]  funct3_m;
  logic [31:0] rdata_m;
  logic        mem_valid_m;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misaligned_m;
`endif

  modport master (
    output re_m, we_m, addr_m, wdata_m, funct3_m,
    input  rdata_m, mem_valid_m
`ifdef DMEM_MISALIGN_TRAP_EN
    , input misaligned_m
`endif
  );

  modport slave (
    input  re_m, we_m, addr_m, wdata_m, funct3_m,
    output rdata_m, mem_valid_m
`ifdef DMEM_MISALIGN_TRAP_EN
    , output misaligned_m
`endif
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the memory stage. Stores commit in one cycle;
//   loads complete after READ_LATENCY cycles with a one-cycle mem_valid_m
//   pulse, which the hazard unit uses to hold the pipeline while a load is
//   outstanding. Holds the word array, byte-lane store merging and load
//   sign/zero extension.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_responder_if.slave (request in, rdata_m/mem_valid_m out)
// Parameters
//   DEPTH_WORDS   32-bit words in the array (power of two)
//   READ_LATENCY  load latency in cycles, 1..15
// Optional feature
//   DMEM_MISALIGN_TRAP_EN: adds misaligned_m; misaligned stores are dropped
//   and misaligned loads return 0 with misaligned_m set alongside the pulse.
//
// state | meaning
// IDLE  | no load outstanding; stores commit here
// WAIT  | load accepted, latency counter running down
// DONE  | rdata_m valid, mem_valid_m high for this cycle only
module dmem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LOAD_CNT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next, cnt_dec;
  logic        store_en;
  logic        capture;
  logic [31:0] rdata_q;
  logic [31:0] load_data;
  logic [3:0]  byte_en;
  logic [31:0] store_data;
  logic        load_mis;
  logic        store_mis;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [31:0]   word;
  logic          unused_addr;

  assign widx        = bus.addr_m[AW+1:2];
  assign word        = mem[widx];
  assign unused_addr = ^bus.addr_m[31:AW+2];
  assign cnt_dec     = cnt - 4'd1;

  always_comb begin
    load_mis  = 1'b0;
    store_mis = 1'b0;
    case (bus.funct3_m)
      3'b001, 3'b101: load_mis = bus.addr_m[0];
      3'b010:         load_mis = (bus.addr_m[1:0] != 2'b00);
      default:        load_mis = 1'b0;
    endcase
    case (bus.funct3_m)
      3'b001:  store_mis = bus.addr_m[0];
      3'b010:  store_mis = (bus.addr_m[1:0] != 2'b00);
      default: store_mis = 1'b0;
    endcase
  end

  // Load path: pick the byte/half out of the addressed word, then extend.
  always_comb begin
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    sel_b = 8'h00;
    sel_h = 16'h0000;
    case (bus.addr_m[1:0])
      2'd0:    sel_b = word[7:0];
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      default: sel_b = word[31:24];
    endcase
    sel_h = bus.addr_m[1] ? word[31:16] : word[15:0];
    case (bus.funct3_m)
      3'b000:  load_data = {{24{sel_b[7]}}, sel_b};
      3'b001:  load_data = {{16{sel_h[15]}}, sel_h};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'h0, sel_b};
      3'b101:  load_data = {16'h0, sel_h};
      default: load_data = 32'h0;
    endcase
  end

  // Store path: lane enables and data replicated into the addressed lanes.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = 32'h0;
    case (bus.funct3_m)
      3'b000: begin
        byte_en    = 4'b0001 << bus.addr_m[1:0];
        store_data = {4{bus.wdata_m[7:0]}};
      end
      3'b001: begin
        byte_en    = bus.addr_m[1] ? 4'b1100 : 4'b0011;
        store_data = {2{bus.wdata_m[15:0]}};
      end
      3'b010: begin
        byte_en    = 4'b1111;
        store_data = bus.wdata_m;
      end
      default: begin
        byte_en    = 4'b0000;
        store_data = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    store_en   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.we_m) begin
          store_en = 1'b1;
        end else if (bus.re_m) begin
          if (READ_LATENCY == 1) begin
            capture    = 1'b1;
            state_next = DONE;
          end else begin
            cnt_next   = LOAD_CNT;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.re_m) begin
          cnt_next   = 4'd0;
          state_next = IDLE;
        end else begin
          // Terminal count on the decremented value so that WAIT lasts
          // READ_LATENCY-1 cycles and the pulse lands READ_LATENCY after IDLE.
          cnt_next = cnt_dec;
          if (cnt_dec == 4'd0) begin
            capture    = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        cnt_next   = 4'd0;
        state_next = IDLE;
      end
    endcase
  end

  logic write_go;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign write_go = store_en && !store_mis;
`else
  assign write_go = store_en;
  logic unused_mis;
  assign unused_mis = load_mis ^ store_mis;
`endif

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (write_go) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[widx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else if (capture) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      rdata_q <= load_mis ? 32'h0 : load_data;
`else
      rdata_q <= load_data;
`endif
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;
  // Store: flags the cycle after the request. Load: coincides with DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= (store_en && store_mis) || (capture && load_mis);
  end
  assign bus.misaligned_m = mis_q;
`endif

  assign bus.rdata_m     = rdata_q;
  assign bus.mem_valid_m = (state == DONE);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int RL    = 2;
  localparam int BYTES = DEPTH * 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int pulses = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [BYTES];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: every load-complete pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.mem_valid_m === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: got rdata %h want no pulse", bus.rdata_m);
      end else begin
        check("load_data", bus.rdata_m, exp_q.pop_front());
      end
    end
  end

  // Byte-addressed reference memory; addresses wrap at the array size.
  function automatic int wrap(input logic [31:0] addr);
    return int'(addr & 32'(BYTES - 1));
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    int a;
    a = wrap(addr);
    case (f3)
      3'b000: ref_mem[a] = wd[7:0];
      3'b001: begin
        a = a & ~1;
        ref_mem[a]   = wd[7:0];
        ref_mem[a+1] = wd[15:8];
      end
      3'b010: begin
        a = a & ~3;
        for (int k = 0; k < 4; k++) ref_mem[a+k] = wd[8*k +: 8];
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    int a, ah, aw;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    a  = wrap(addr);
    ah = a & ~1;
    aw = a & ~3;
    b  = ref_mem[a];
    h  = {ref_mem[ah+1], ref_mem[ah]};
    w  = {ref_mem[aw+3], ref_mem[aw+2], ref_mem[aw+1], ref_mem[aw]};
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b010:  return w;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Drivers are entered #1 after a rising edge with the DUT in IDLE.
  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    bus.we_m     = 1'b1;
    bus.addr_m   = addr;
    bus.funct3_m = f3;
    bus.wdata_m  = wd;
    @(posedge clk); #1;
    bus.we_m = 1'b0;
    bus.re_m = 1'b0;
    model_store(addr, f3, wd);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    bus.re_m     = 1'b1;
    bus.addr_m   = addr;
    bus.funct3_m = f3;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.mem_valid_m === 1'b1) got = 1'b1;
    end
    check("load_latency", 32'(n), 32'(RL));
    bus.re_m = 1'b0;
    if (!got) exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3);
    exp_q.push_back(model_load(addr, f3));
    run_load(addr, f3);
  endtask

  task automatic load_exp(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] exp);
    exp_q.push_back(exp);
    run_load(addr, f3);
  endtask

  initial begin
    int p0;
    bus.re_m     = 1'b0;
    bus.we_m     = 1'b0;
    bus.addr_m   = 32'h0;
    bus.wdata_m  = 32'h0;
    bus.funct3_m = 3'b010;
    #23 rst_n = 1'b1;

    repeat (10) begin
      @(negedge clk);
      check("idle_valid", {31'h0, bus.mem_valid_m}, 32'h0);
      check("idle_rdata", bus.rdata_m, 32'h0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 64; i += 4) do_store(32'(i), 3'b010, $urandom);

    // Word store and load, byte store with sign/zero extension.
    do_store(32'h10, 3'b010, 32'hDEADBEEF);
    load_exp(32'h10, 3'b010, 32'hDEADBEEF);
    do_store(32'h11, 3'b000, 32'hFFFFFF80);
    load_exp(32'h11, 3'b000, 32'hFFFFFF80);
    load_exp(32'h11, 3'b100, 32'h00000080);
    load_exp(32'h10, 3'b010, 32'hDEAD80EF);

    // Half store into the upper half of a word.
    do_store(32'h20, 3'b010, 32'h12345678);
    do_store(32'h22, 3'b001, 32'hAAAA8001);
    load_exp(32'h22, 3'b001, 32'hFFFF8001);
    load_exp(32'h22, 3'b101, 32'h00008001);
    load_exp(32'h20, 3'b101, 32'h00005678);
    load_exp(32'h20, 3'b010, 32'h80015678);
    load_exp(32'h20, 3'b011, 32'h00000000);

    // Reset in the middle of WAIT: the load dies silently.
    p0 = pulses;
    bus.re_m     = 1'b1;
    bus.addr_m   = 32'h10;
    bus.funct3_m = 3'b010;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    bus.re_m = 1'b0;
    rst_n    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_pulse", 32'(pulses - p0), 32'h0);
    load_exp(32'h10, 3'b010, 32'hDEAD80EF);

    // Address wrap.
    do_store(32'h10 + 32'(BYTES), 3'b010, 32'hCAFEF00D);
    load_exp(32'h10, 3'b010, 32'hCAFEF00D);

    // Store and load together: store wins, no pulse.
    p0 = pulses;
    bus.re_m = 1'b1;
    do_store(32'h14, 3'b010, 32'h11223344);
    repeat (RL + 2) @(posedge clk);
    #1;
    check("store_wins_no_pulse", 32'(pulses - p0), 32'h0);
    load_exp(32'h14, 3'b010, 32'h11223344);

    // Undefined store size writes nothing.
    do_store(32'h14, 3'b011, 32'hFFFFFFFF);
    load_exp(32'h14, 3'b010, 32'h11223344);

    // Randomized mix of stores and loads inside an initialised window,
    // with random aliasing through the upper address bits.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3)) * 32'(BYTES);
      if ($urandom_range(0, 1) == 0) do_store(a, 3'($urandom_range(0, 3)), $urandom);
      else                           load(a, 3'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
